// File: rtl/lfm_pkg.sv
// lfm_pkg: shared enums and constants for the LFM sweep generator
package lfm_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/lfm_sweep_gen_if.sv
// lfm_sweep_gen_if: control/result bundle of the LFM sweep generator
//   i_* : start/abort pulses and sweep configuration (driven by master)
//   o_* : frequency word, phase, valid/dir/pulse/busy/done/cfg_err status (driven by slave)
interface lfm_sweep_gen_if #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 16,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 8
);
    logic               i_start;
    logic               i_abort;
    logic [1:0]         i_mode;
    logic [ACC_W-1:0]   i_start_freq;
    logic [ACC_W-1:0]   i_stop_freq;
    logic [ACC_W-1:0]   i_step_freq;
    logic [DWELL_W-1:0] i_dwell;
    logic [CNT_W-1:0]   i_num_sweeps;
    logic [ACC_W-1:0]   o_pinc;
    logic [PHASE_W-1:0] o_phase;
    logic               o_valid;
    logic               o_ramp_dir;
    logic               o_sweep_pulse;
    logic               o_busy;
    logic               o_done;
    logic               o_cfg_err;

    modport master (
        output i_start, i_abort, i_mode, i_start_freq, i_stop_freq, i_step_freq, i_dwell, i_num_sweeps,
        input  o_pinc, o_phase, o_valid, o_ramp_dir, o_sweep_pulse, o_busy, o_done, o_cfg_err
    );

    modport slave (
        input  i_start, i_abort, i_mode, i_start_freq, i_stop_freq, i_step_freq, i_dwell, i_num_sweeps,
        output o_pinc, o_phase, o_valid, o_ramp_dir, o_sweep_pulse, o_busy, o_done, o_cfg_err
    );
endinterface

// File: rtl/lfm_phase_acc.sv
// lfm_phase_acc: phase accumulator with MSB truncation and optional LFSR dither
//   clk, rst_n : clock, async active-low reset
//   run        : accumulate this cycle (otherwise the accumulator clears to 0)
//   adv        : output sample valid; advances the dither LFSR
//   pinc       : frequency word added each run cycle
//   phase      : acc[ACC_W-1 -: PHASE_W], dithered when LFM_DITHER_EN is defined
module lfm_phase_acc #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               adv,
    input  logic [ACC_W-1:0]   pinc,
    output logic [PHASE_W-1:0] phase
);
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb acc_d = run ? acc_q + pinc : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;

`ifdef LFM_DITHER_EN
    localparam int LSB_W = ACC_W - PHASE_W;
    localparam int SH_L  = LSB_W >= 16 ? LSB_W - 16 : 0;
    localparam int SH_R  = LSB_W >= 16 ? 0 : 16 - LSB_W;

    logic [15:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] dith, sum;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; its bits sit just below the phase cut
    always_comb begin
        lfsr_d = adv ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        dith   = (ACC_W'(lfsr_q) << SH_L) >> SH_R;
        sum    = acc_q + dith;
        phase  = adv ? sum[ACC_W-1 -: PHASE_W] : acc_q[ACC_W-1 -: PHASE_W];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
`else
    assign phase = acc_q[ACC_W-1 -: PHASE_W];
`endif
endmodule

// File: rtl/lfm_sweep_gen.sv
// lfm_sweep_gen: LFM chirp controller (up/down/triangle, dwell, repeat, abort) feeding a phase accumulator
//   clk, rst_n : 100 MHz clock, async active-low reset
//   bus        : lfm_sweep_gen_if.slave; i_* start/abort/config in, o_* pinc/phase/status out
//   LFM_DITHER_EN (optional define) enables LFSR phase dither inside lfm_phase_acc
module lfm_sweep_gen
    import lfm_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 16,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 8
) (
    input logic            clk,
    input logic            rst_n,
    lfm_sweep_gen_if.slave bus
);
    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [ACC_W-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d, pinc_q, pinc_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0]   num_q, num_d, cnt_q, cnt_d, cnt_inc;
    logic               dir_q, dir_d, cfg_err_q, cfg_err_d;
    logic               cfg_ok, step_now, at_stop, at_start, sweep_end, last, nxt_dir;
    logic [ACC_W:0]     up_sum, dn_dif;
    logic [ACC_W-1:0]   up_nxt, dn_nxt, nxt_pinc;

    assign cfg_ok = bus.i_start_freq <= bus.i_stop_freq && bus.i_step_freq != '0 && bus.i_mode != MODE_RSVD;

    // Ramp arithmetic is one bit wider so overflow/underflow clamps to the bound instead of wrapping
    always_comb begin
        step_now  = dwell_cnt_q == dwell_q;
        at_stop   = pinc_q == stop_q;
        at_start  = pinc_q == start_q;
        up_sum    = {1'b0, pinc_q} + {1'b0, step_q};
        dn_dif    = {1'b0, pinc_q} - {1'b0, step_q};
        up_nxt    = up_sum > {1'b0, stop_q} ? stop_q : up_sum[ACC_W-1:0];
        dn_nxt    = (dn_dif[ACC_W] || dn_dif[ACC_W-1:0] < start_q) ? start_q : dn_dif[ACC_W-1:0];
        // Triangle with start==stop degenerates to a single held value per sweep
        sweep_end = step_now && (mode_q == MODE_UP   ? at_stop :
                                 mode_q == MODE_DOWN ? at_start :
                                 dir_q               ? at_stop && at_start : at_start);
        nxt_pinc  = mode_q == MODE_UP   ? (at_stop ? start_q : up_nxt) :
                    mode_q == MODE_DOWN ? (at_start ? stop_q : dn_nxt) :
                    dir_q               ? (at_stop ? (at_start ? start_q : dn_nxt) : up_nxt) :
                                          (at_start ? start_q : dn_nxt);
        nxt_dir   = mode_q != MODE_TRI ? dir_q : dir_q ? !(at_stop && !at_start) : at_start;
        cnt_inc   = cnt_q + 1'b1;
        last      = sweep_end && num_q != '0 && cnt_inc == num_q;
    end

    always_comb begin
        state_d   = state_q;
        cfg_err_d = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.i_start && !bus.i_abort) begin
                state_d   = cfg_ok ? ST_LOAD : ST_IDLE;
                cfg_err_d = !cfg_ok;
            end
            ST_LOAD:  state_d = bus.i_abort ? ST_IDLE : ST_SWEEP;
            ST_SWEEP: state_d = bus.i_abort ? ST_IDLE : last ? ST_DONE : ST_SWEEP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        num_d       = num_q;
        pinc_d      = pinc_q;
        dir_d       = dir_q;
        dwell_cnt_d = dwell_cnt_q;
        cnt_d       = cnt_q;
        if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            mode_d  = mode_t'(bus.i_mode);
            start_d = bus.i_start_freq;
            stop_d  = bus.i_stop_freq;
            step_d  = bus.i_step_freq;
            dwell_d = bus.i_dwell;
            num_d   = bus.i_num_sweeps;
        end
        if (state_q == ST_LOAD) begin
            pinc_d      = mode_q == MODE_DOWN ? stop_q : start_q;
            dir_d       = mode_q != MODE_DOWN;
            dwell_cnt_d = '0;
            cnt_d       = '0;
        end
        if (state_q == ST_SWEEP) begin
            dwell_cnt_d = step_now ? '0 : dwell_cnt_q + 1'b1;
            pinc_d      = step_now ? nxt_pinc : pinc_q;
            dir_d       = step_now ? nxt_dir : dir_q;
            cnt_d       = sweep_end ? cnt_inc : cnt_q;
        end
        if (state_d != ST_SWEEP) begin
            pinc_d = '0;
            dir_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_UP;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            num_q       <= '0;
            pinc_q      <= '0;
            dir_q       <= 1'b0;
            dwell_cnt_q <= '0;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            num_q       <= num_d;
            pinc_q      <= pinc_d;
            dir_q       <= dir_d;
            dwell_cnt_q <= dwell_cnt_d;
            cnt_q       <= cnt_d;
            cfg_err_q   <= cfg_err_d;
        end

    lfm_phase_acc #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == ST_SWEEP && state_d == ST_SWEEP),
        .adv   (state_q == ST_SWEEP),
        .pinc  (pinc_q),
        .phase (bus.o_phase)
    );

    assign bus.o_pinc        = pinc_q;
    assign bus.o_ramp_dir    = dir_q;
    assign bus.o_valid       = state_q == ST_SWEEP;
    assign bus.o_busy        = state_q == ST_LOAD || state_q == ST_SWEEP;
    assign bus.o_done        = state_q == ST_DONE;
    assign bus.o_cfg_err     = cfg_err_q;
    assign bus.o_sweep_pulse = state_q == ST_SWEEP && sweep_end;
endmodule
